pearson_hash_stream: RTL
========================

// Module: pearson_hash_stream
// PURPOSE
//   Streaming, parametrised Pearson hasher: successor to the fixed 8-octet PearsonHash block.
//   Accepts variable-length messages as multi-beat valid/ready bursts and hashes one byte per cycle.
//   Produces a HASH_OCTETS-wide digest, one independent Pearson lane per octet.
//   Permutation table is loadable at run time. Sits between packet-field extraction and flow lookup.
// PARAMETERS
//   BLOCK_SIZE_IN_OCTETS  8   bytes per input beat (>=1)
//   HASH_OCTETS           2   digest width in octets = number of lanes (1..8)
//   LEN_W                 16  width of msg_len_out (saturating byte count)
// PORTS
//   clk             in   1         single clock; all logic on rising edge
//   reset           in   1         synchronous, active-low reset
//   key_write_enable in  1         table write strobe
//   key_write_ready out  1         table write accepted when high
//   key_idx_in      in   8         table index to write
//   key_byte_in     in   8         value written to T[key_idx_in]
//   in_valid        in   1         input beat valid
//   in_ready        out  1         input beat accepted when in_valid & in_ready
//   in_data         in   8*BLOCK   beat bytes; byte 0 = in_data[7:0], hashed first
//   in_len          in   clog2(BLOCK)+1  valid bytes in beat, 1..BLOCK; 0 means BLOCK
//   in_last         in   1         beat ends the message
//   hash_valid      out  1         digest valid
//   hash_ready      in   1         digest consumed when hash_valid & hash_ready
//   hash_out        out  8*HASH_OCTETS  lane j at [8j+7:8j]
//   msg_len_out     out  LEN_W     bytes in hashed message, saturates at 2^LEN_W-1
// BEHAVIOUR
//   Reset (reset==0 at edge): state IDLE; T[i]=i for all i; lanes, counters cleared;
//     in_ready=1, key_write_ready=1, hash_valid=0, hash_out=0, msg_len_out=0. Aborts any message.
//   Hash step per lane j: h_j <= T[h_j ^ byte]; seed h_j = j at message start.
//   FSM: IDLE -> (in accepted) HASH; HASH consumes byte k of latched beat each cycle, k=0..len-1;
//     after byte len-1: if latched last -> DONE else -> WAIT_BEAT; WAIT_BEAT -> (in accepted) HASH;
//     DONE -> (hash_ready) IDLE.
//   in_ready = 1 in IDLE and WAIT_BEAT only; beat data/len/last latched on acceptance.
//   key_write_ready = 1 in IDLE only; writes in other states ignored (no table change).
//   Key write and beat acceptance in same IDLE cycle: both taken; write visible to first HASH byte.
//   Latency: beat of L bytes occupies L HASH cycles; hash_valid rises the cycle after last byte.
//   DONE: hash_out, msg_len_out held stable until handshake; hash_valid drops the cycle after.
//   msg_len_out increments per hashed byte, saturates, no wrap; cleared at message start.
//   Lane index arithmetic mod 256 (8-bit XOR, no carry).
// STRUCTURE
//   Package pearson_pkg: state enum {IDLE,HASH,WAIT_BEAT,DONE}; TABLE_DEPTH=256; OCTET=8.
//   Sub-module pearson_table: 256x8 register array, one sync write port,
//     HASH_OCTETS combinational read ports, sync reset to identity.
//   Top: FSM, beat latch, byte index counter, lane registers, length counter.
// TESTING
//   1 Identity table, HASH_OCTETS=2, one beat 0x5A len1 last -> hash_out=16'h5B5A, msg_len_out=1.
//   2 Load T[i]=255-i (256 writes), beat 16'h0000 len2 last -> hash 16'h0100; len1 -> 16'hFEFF.
//   3 Identity, beat 64'h0807060504030201 len8 !last then 0x09 len1 last
//     -> hash_out=16'h0001, msg_len_out=9; hash_valid 10 cycles after first acceptance.
//   4 Hold hash_ready=0 for 20 cycles in DONE -> hash_out stable, in_ready=0, key writes ignored.
//   5 Assert reset during HASH of 8-byte beat -> next cycle IDLE, hash_valid=0, T identity restored.
//   6 in_len=0 with in_last on identity table, bytes 0x01 x8 -> treated as 8 bytes, hash 16'h0100.

Source files
------------

// File: rtl/pearson_hash_stream_pkg.sv
// Shared types and constants for the streaming Pearson hasher.
// Imported by the table, interface users and top.
package pearson_pkg;
  localparam int TABLE_DEPTH = 256;
  localparam int OCTET = 8;

  typedef enum logic [1:0] {
    IDLE,
    HASH,
    WAIT_BEAT,
    DONE
  } state_e;
endpackage

// File: rtl/pearson_hash_stream_if.sv
// Key-write, input-beat and digest handshakes of the Pearson hasher.
// The master drives requests; the slave is the hasher.
interface pearson_hash_stream_if #(
  parameter int BLOCK_SIZE_IN_OCTETS = 8,
  parameter int HASH_OCTETS = 2,
  parameter int LEN_W = 16
);
  localparam int LW = $clog2(BLOCK_SIZE_IN_OCTETS) + 1;

  logic                            key_write_enable;
  logic                            key_write_ready;
  logic [7:0]                      key_idx_in;
  logic [7:0]                      key_byte_in;
  logic                            in_valid;
  logic                            in_ready;
  logic [8*BLOCK_SIZE_IN_OCTETS-1:0] in_data;
  logic [LW-1:0]                   in_len;
  logic                            in_last;
  logic                            hash_valid;
  logic                            hash_ready;
  logic [8*HASH_OCTETS-1:0]        hash_out;
  logic [LEN_W-1:0]                msg_len_out;

  modport master (
    output key_write_enable, key_idx_in, key_byte_in,
    output in_valid, in_data, in_len, in_last,
    output hash_ready,
    input  key_write_ready, in_ready,
    input  hash_valid, hash_out, msg_len_out
  );

  modport slave (
    input  key_write_enable, key_idx_in, key_byte_in,
    input  in_valid, in_data, in_len, in_last,
    input  hash_ready,
    output key_write_ready, in_ready,
    output hash_valid, hash_out, msg_len_out
  );
endinterface

// File: rtl/pearson_hash_stream_table.sv
// 256x8 permutation table: one sync write port, PORTS async reads.
// Reset reloads the identity permutation.
module pearson_table
  import pearson_pkg::*;
#(
  parameter int PORTS = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we_i,
  input  logic [7:0]            wa_i,
  input  logic [7:0]            wd_i,
  input  logic [PORTS-1:0][7:0] ra_i,
  output logic [PORTS-1:0][7:0] rd_o
);
  logic [7:0] mem_q [TABLE_DEPTH];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < TABLE_DEPTH; i++)
        mem_q[i] <= 8'(i);
    end else if (we_i) begin
      mem_q[wa_i] <= wd_i;
    end
  end

  for (genvar p = 0; p < PORTS; p++) begin : g_rd
    assign rd_o[p] = mem_q[ra_i[p]];
  end
endmodule

// File: rtl/pearson_hash_stream.sv
// Streaming Pearson hasher: one byte per cycle, one lane per
// digest octet, run-time loadable permutation table.
module pearson_hash_stream
  import pearson_pkg::*;
#(
  parameter int BLOCK_SIZE_IN_OCTETS = 8,
  parameter int HASH_OCTETS = 2,
  parameter int LEN_W = 16
) (
  input logic clk,
  input logic reset,
  pearson_hash_stream_if.slave bus
);
  localparam int B = BLOCK_SIZE_IN_OCTETS;
  localparam int H = HASH_OCTETS;
  localparam int LW = $clog2(B) + 1;
  localparam logic [LW-1:0] FULL = LW'(B);

  state_e              state_q;
  logic [8*B-1:0]      beat_q;
  logic [LW-1:0]       len_q;
  logic [LW-1:0]       idx_q;
  logic                last_q;
  logic [H-1:0][7:0]   lane_q;
  logic [LEN_W-1:0]    cnt_q;

  logic [H-1:0][7:0]   ra;
  logic [H-1:0][7:0]   rd;
  logic [7:0]          byte_w;
  logic [LW-1:0]       len_eff;
  logic                accept;
  logic                kwe;

  assign bus.in_ready        = (state_q == IDLE) || (state_q == WAIT_BEAT);
  assign bus.key_write_ready = (state_q == IDLE);
  assign bus.hash_valid      = (state_q == DONE);
  assign bus.hash_out        = lane_q;
  assign bus.msg_len_out     = cnt_q;

  assign accept = bus.in_valid && bus.in_ready;
  assign kwe    = bus.key_write_enable && (state_q == IDLE);
  assign byte_w = beat_q[{idx_q, 3'b000} +: 8];

  // Zero (or an out-of-range count) means a full beat.
  assign len_eff = (bus.in_len == '0 || bus.in_len > FULL)
                 ? FULL : bus.in_len;

  for (genvar j = 0; j < H; j++) begin : g_ra
    assign ra[j] = lane_q[j] ^ byte_w;
  end

  pearson_table #(.PORTS(H)) u_table (
    .clk  (clk),
    .reset(reset),
    .we_i (kwe),
    .wa_i (bus.key_idx_in),
    .wd_i (bus.key_byte_in),
    .ra_i (ra),
    .rd_o (rd)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      beat_q  <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      lane_q  <= '0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE, WAIT_BEAT: begin
          if (accept) begin
            beat_q  <= bus.in_data;
            len_q   <= len_eff;
            last_q  <= bus.in_last;
            idx_q   <= '0;
            state_q <= HASH;
            if (state_q == IDLE) begin
              cnt_q <= '0;
              for (int j = 0; j < H; j++)
                lane_q[j] <= 8'(j);
            end
          end
        end
        HASH: begin
          lane_q <= rd;
          if (cnt_q != '1)
            cnt_q <= cnt_q + 1'b1;
          idx_q <= idx_q + 1'b1;
          if (idx_q + 1'b1 == len_q)
            state_q <= last_q ? DONE : WAIT_BEAT;
        end
        DONE: begin
          if (bus.hash_ready)
            state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
